imm_gen_pipe: RTL and testbench

Parametrised, pipelined immediate generator for the decode stage. It takes a raw 32-bit RISC-V instruction plus its PC and decodes the immediate format directly from the opcode/funct3, with no external op-select. It produces a sign- or zero-extended XLEN-wide immediate and a PC-relative branch/jump/AUIPC target. The block sits between fetch and the register-read/execute stages, behind a valid/ready handshake with a 2-entry skid buffer, so it can absorb back-pressure without a combinational ready path.

---
 rtl/imm_gen_pipe.sv | 182 ++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate decoder with PC-relative target. Decoded entries are held in a
// main (output) register backed by one skid register, so in_ready depends only on local state.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);
    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_CSRI  = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } entry_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] shamt5, shamt6, zimm;
    entry_t          dec;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Signed size casts give the sign extension; unsigned casts zero-extend.
    assign imm_i  = XLEN'($signed(in_instr[31:20]));
    assign imm_s  = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b  = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
    assign shamt5 = XLEN'(in_instr[24:20]);
    assign shamt6 = XLEN'(in_instr[25:20]);
    assign zimm   = XLEN'(in_instr[19:15]);

    always_comb begin
        dec    = '0;
        dec.pc = in_pc;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                dec.fmt = FMT_I;
                dec.imm = imm_i;
            end
            OPC_OPIMM: begin
                if (is_shift) begin
                    dec.fmt     = FMT_SHAMT;
                    dec.imm     = (XLEN == 32) ? shamt5 : shamt6;
                    // RV32 keeps the 5-bit amount but flags the out-of-range bit.
                    dec.illegal = (XLEN == 32) && in_instr[25];
                end else begin
                    dec.fmt = FMT_I;
                    dec.imm = imm_i;
                end
            end
            OPC_OPIMM32: begin
                if (XLEN == 32) begin
                    dec.illegal = 1'b1;
                end else if (is_shift) begin
                    dec.fmt = FMT_SHAMT;
                    dec.imm = shamt5;
                end else begin
                    dec.fmt = FMT_I;
                    dec.imm = imm_i;
                end
            end
            OPC_STORE: begin
                dec.fmt = FMT_S;
                dec.imm = imm_s;
            end
            OPC_BRANCH: begin
                dec.fmt = FMT_B;
                dec.imm = imm_b;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.fmt = FMT_U;
                dec.imm = imm_u;
            end
            OPC_JAL: begin
                dec.fmt = FMT_J;
                dec.imm = imm_j;
            end
            OPC_SYSTEM: begin
                if (funct3 inside {3'b101, 3'b110, 3'b111}) begin
                    dec.fmt = FMT_CSRI;
                    dec.imm = zimm;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.fmt == FMT_B || dec.fmt == FMT_J || opcode == OPC_AUIPC)
            dec.target = in_pc + dec.imm;
    end

    entry_t main_q, main_d, skid_q, skid_d;
    logic   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic   accept, fire;

    assign in_ready  = !skid_vld_q;
    assign out_valid = main_vld_q;
    assign accept    = in_valid && in_ready && !flush;
    assign fire      = main_vld_q && out_ready;

    // Skid is only ever full while main is full, so an accept never sees skid occupied.
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (fire && skid_vld_q) begin
            main_d     = skid_q;
            skid_vld_d = 1'b0;
        end else if (accept && (!main_vld_q || fire)) begin
            main_d     = dec;
            main_vld_d = 1'b1;
        end else if (accept) begin
            skid_d     = dec;
            skid_vld_d = 1'b1;
        end else if (fire) begin
            main_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_target  = main_q.target;
    assign out_pc      = main_q.pc;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are
// checked every cycle against a 2-deep FIFO model with a table-driven decoder.
module tb_imm_gen_pipe;
    logic        clk, rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32, out_target32, out_pc32;
    logic [2:0]  out_fmt32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64, out_target64, out_pc64;
    logic [2:0]  out_fmt64;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .out_target(out_target32), .out_pc(out_pc32),
        .out_illegal(out_illegal32)
    );
    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_target(out_target64), .out_pc(out_pc64),
        .out_illegal(out_illegal64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
        return v[bits-1] ? (v | (~64'd0 << bits)) : v;
    endfunction

    // Reference decoder straight from the opcode table.
    function automatic void ref_dec(input int xl, input logic [31:0] i, input logic [63:0] pc,
                                    output logic [2:0] fmt, output logic [63:0] imm,
                                    output logic [63:0] tgt, output logic ill);
        logic [63:0] m  = (xl == 32) ? 64'hFFFF_FFFF : ~64'd0;
        logic [2:0]  f3 = i[14:12];
        fmt = 0; imm = 0; tgt = 0; ill = 0;
        case (i[6:0])
            7'h03, 7'h67: begin fmt = 1; imm = sx(64'(i[31:20]), 12); end
            7'h13, 7'h1B: begin
                if (i[6:0] == 7'h1B && xl == 32) ill = 1;
                else if (f3 == 3'd1 || f3 == 3'd5) begin
                    fmt = 6;
                    imm = (xl == 64 && i[6:0] == 7'h13) ? 64'(i[25:20]) : 64'(i[24:20]);
                    ill = (xl == 32) && i[25];
                end else begin fmt = 1; imm = sx(64'(i[31:20]), 12); end
            end
            7'h23: begin fmt = 2; imm = sx(64'({i[31:25], i[11:7]}), 12); end
            7'h63: begin fmt = 3; imm = sx(64'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13); end
            7'h37, 7'h17: begin fmt = 4; imm = sx(64'({i[31:12], 12'b0}), 32); end
            7'h6F: begin fmt = 5; imm = sx(64'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21); end
            7'h73: if (f3 >= 3'd5) begin fmt = 7; imm = 64'(i[19:15]); end
            default: ill = 1;
        endcase
        if (fmt == 3 || fmt == 5 || i[6:0] == 7'h17) tgt = pc + imm;
        imm = imm & m;
        tgt = tgt & m;
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } ent_t;
    ent_t q[$];

    // Capacity-2 FIFO; in_ready is "fewer than two held", out_valid is "non-empty".
    always @(posedge clk or posedge rst) begin
        if (rst || flush) q.delete();
        else if (in_valid && q.size() < 2) begin
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            q.push_back('{in_instr, in_pc});
        end else if (q.size() > 0 && out_ready) void'(q.pop_front());
    end

    initial begin
        logic [2:0]  f;
        logic [63:0] im, tg;
        logic        il;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_out_valid32", out_valid32, 0);
                chk("rst_in_ready32", in_ready32, 1);
                chk("rst_out_valid64", out_valid64, 0);
                chk("rst_in_ready64", in_ready64, 1);
                chk("rst_outs32", {out_imm32, out_target32}, 0);
                chk("rst_pc_fmt_ill32", {out_pc32, out_fmt32, out_illegal32}, 0);
                chk("rst_outs64", out_imm64 | out_target64 | out_pc64, 0);
                chk("rst_fmt_ill64", {out_fmt64, out_illegal64}, 0);
            end else begin
                chk("in_ready32", in_ready32, q.size() < 2);
                chk("out_valid32", out_valid32, q.size() != 0);
                chk("in_ready64", in_ready64, q.size() < 2);
                chk("out_valid64", out_valid64, q.size() != 0);
                if (q.size() != 0) begin
                    ref_dec(32, q[0].instr, q[0].pc, f, im, tg, il);
                    chk("imm32", out_imm32, im);
                    chk("fmt32", out_fmt32, f);
                    chk("target32", out_target32, tg);
                    chk("pc32", out_pc32, q[0].pc[31:0]);
                    chk("illegal32", out_illegal32, il);
                    ref_dec(64, q[0].instr, q[0].pc, f, im, tg, il);
                    chk("imm64", out_imm64, im);
                    chk("fmt64", out_fmt64, f);
                    chk("target64", out_target64, tg);
                    chk("pc64", out_pc64, q[0].pc);
                    chk("illegal64", out_illegal64, il);
                end
            end
        end
    end

    task automatic pin(input string nm, input int xl, input logic [31:0] ins, input logic [63:0] pc,
                       input logic [2:0] ef, input logic [63:0] ei, input logic [63:0] et,
                       input logic eil);
        logic [2:0] f; logic [63:0] im, tg; logic il;
        ref_dec(xl, ins, pc, f, im, tg, il);
        chk({"model_fmt_", nm}, f, ef);
        chk({"model_imm_", nm}, im, ei);
        chk({"model_tgt_", nm}, tg, et);
        chk({"model_ill_", nm}, il, eil);
    endtask

    // One entry into an empty pipe; checks the chosen instance one cycle after accept.
    task automatic single(input string nm, input logic [31:0] ins, input logic [63:0] pc,
                          input logic [2:0] ef, input logic [63:0] ei, input logic [63:0] et,
                          input logic eil, input bit is64);
        in_valid = 1; in_instr = ins; in_pc = pc; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        if (is64) begin
            chk({nm, "_valid"}, out_valid64, 1);
            chk({nm, "_fmt"}, out_fmt64, ef);
            chk({nm, "_imm"}, out_imm64, ei);
            chk({nm, "_tgt"}, out_target64, et);
            chk({nm, "_ill"}, out_illegal64, eil);
        end else begin
            chk({nm, "_valid"}, out_valid32, 1);
            chk({nm, "_fmt"}, out_fmt32, ef);
            chk({nm, "_imm"}, out_imm32, ei);
            chk({nm, "_tgt"}, out_target32, et);
            chk({nm, "_ill"}, out_illegal32, eil);
        end
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [31:0] ins, input logic [63:0] pc);
        int  n;
        bit  ok;
        n = 0;
        in_valid = 1; in_instr = ins; in_pc = pc;
        forever begin
            @(negedge clk);
            ok = in_ready32;
            @(posedge clk); #1;
            if (ok) break;
            if (++n > 200) begin
                chk("push_timeout", 1, 0);
                break;
            end
        end
        in_valid = 0;
    endtask

    logic [6:0] opc_tab [12] = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63,
                                 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F};

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 9) != 0) r[6:0] = opc_tab[$urandom_range(0, 11)];
        return r;
    endfunction

    initial begin
        rst = 1; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 1;

        pin("addi", 32, 32'hFFF00093, 64'h0, 3'd1, 64'hFFFF_FFFF, 64'h0, 0);
        pin("beq", 32, 32'hFE000EE3, 64'h100, 3'd3, 64'hFFFF_FFFC, 64'hFC, 0);
        pin("jal", 32, 32'h001000EF, 64'h1000, 3'd5, 64'h800, 64'h1800, 0);
        pin("slli", 32, 32'h00309093, 64'h0, 3'd6, 64'd3, 64'h0, 0);
        pin("srli_b25", 32, 32'h0230D093, 64'h0, 3'd6, 64'd3, 64'h0, 1);
        pin("csrrwi", 32, 32'h300FD073, 64'h0, 3'd7, 64'd31, 64'h0, 0);
        pin("lui64", 64, 32'h800000B7, 64'h0, 3'd4, 64'hFFFF_FFFF_8000_0000, 64'h0, 0);

        repeat (2) @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        single("addi", 32'hFFF00093, 64'h40, 3'd1, 64'hFFFF_FFFF, 64'h0, 0, 0);
        single("beq", 32'hFE000EE3, 64'h100, 3'd3, 64'hFFFF_FFFC, 64'hFC, 0, 0);
        single("jal", 32'h001000EF, 64'h1000, 3'd5, 64'h800, 64'h1800, 0, 0);
        single("slli", 32'h00309093, 64'h8, 3'd6, 64'd3, 64'h0, 0, 0);
        single("srli_b25", 32'h0230D093, 64'hC, 3'd6, 64'd3, 64'h0, 1, 0);
        single("csrrwi", 32'h300FD073, 64'h10, 3'd7, 64'd31, 64'h0, 0, 0);
        single("lui64", 32'h800000B7, 64'h14, 3'd4, 64'hFFFF_FFFF_8000_0000, 64'h0, 0, 1);

        out_ready = 0;
        push(32'h00100093, 64'hA00);
        push(32'h00200093, 64'hB00);
        in_valid = 1; in_instr = 32'h00300093; in_pc = 64'hC00;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready32, 0);
            chk("bp_hold_pc", out_pc32, 32'hA00);
        end
        @(posedge clk); #1;
        out_ready = 1;
        push(32'h00300093, 64'hC00);
        @(negedge clk);
        chk("bp_last_pc", out_pc32, 32'hC00);
        @(posedge clk); #1;

        out_ready = 0;
        push(32'h00100093, 64'hD00);
        push(32'h00200093, 64'hD04);
        in_valid = 1; flush = 1; in_instr = 32'h00300093; in_pc = 64'hD08;
        @(posedge clk); #1;
        in_valid = 0; flush = 0;
        @(negedge clk);
        chk("flush_valid", out_valid32, 0);
        chk("flush_ready", in_ready32, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush_dropped", out_valid32, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc     = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            if (i == 1500) begin
                #2 rst = 1;
                #1;
                chk("midrst_valid", out_valid32, 0);
                chk("midrst_ready", in_ready32, 1);
                chk("midrst_outs", {out_imm32, out_target32, out_pc32, out_fmt32, out_illegal32}, 0);
            end
            if (i == 1503) #2 rst = 0;
            @(posedge clk); #1;
        end

        in_valid = 0; flush = 0; out_ready = 1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
